// File: rtl/project1_nios2_qsys_0_jtag_debug_host_pkg.sv
// Shared definitions for the virtual-JTAG debug host: width defaults and the
// sequencing FSM state encoding.
package project1_nios2_qsys_0_jtag_debug_host_pkg;

  localparam int unsigned TCK_DIV_DEF  = 2;
  localparam int unsigned DR_WIDTH_DEF = 38;
  localparam int unsigned IR_WIDTH_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_UIR  = 3'd1,
    ST_CDR  = 3'd2,
    ST_SDR  = 3'd3,
    ST_UDR  = 3'd4,
    ST_RESP = 3'd5
  } state_e;

  // States that consume whole TCK periods and therefore run the divider.
  function automatic logic is_tck_state(input state_e s);
    return (s == ST_UIR) || (s == ST_CDR) || (s == ST_SDR) || (s == ST_UDR);
  endfunction

endpackage

// File: rtl/project1_nios2_qsys_0_jtag_debug_host_tckgen.sv
// TCK divider: 2*TCK_DIV clk cycles per period, low half first, with
// single-cycle strobes for period start, tck rise and period end.
module project1_nios2_qsys_0_jtag_debug_host_tckgen #(
  parameter int unsigned TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic tck,
  output logic period_start,
  output logic tck_rise,
  output logic period_end
);

  localparam int unsigned CW = $clog2(2 * TCK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(2 * TCK_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(TCK_DIV);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = '0;
    if (run && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tck          = run && (cnt_q >= CNT_HALF);
  assign period_start = run && (cnt_q == '0);
  assign tck_rise     = run && (cnt_q == CNT_HALF);
  assign period_end   = run && (cnt_q == CNT_LAST);

endmodule

// File: rtl/project1_nios2_qsys_0_jtag_debug_host.sv
// Virtual-JTAG debug host: accepts one IR/DR command, walks UIR-CDR-SDR-UDR
// on a divided TCK, and returns the DR bits captured from vji_tdo.
module project1_nios2_qsys_0_jtag_debug_host
  import project1_nios2_qsys_0_jtag_debug_host_pkg::*;
#(
  parameter int unsigned TCK_DIV  = TCK_DIV_DEF,
  parameter int unsigned DR_WIDTH = DR_WIDTH_DEF,
  parameter int unsigned IR_WIDTH = IR_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic                vji_tck,
  output logic                vji_tdi,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic                vji_tdo
);

  localparam int unsigned BW = $clog2(DR_WIDTH + 1);
  localparam logic [BW-1:0] BITS_ALL = BW'(DR_WIDTH);

  state_e              state_q, state_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic [DR_WIDTH-1:0] data_q, data_d;
  logic [DR_WIDTH-1:0] rsp_q, rsp_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic                rsp_valid_q, rsp_valid_d;

  logic run;
  logic period_start;
  logic tck_rise;
  logic period_end;

  assign run = is_tck_state(state_q);

  project1_nios2_qsys_0_jtag_debug_host_tckgen #(
    .TCK_DIV (TCK_DIV)
  ) u_tckgen (
    .clk          (clk),
    .reset_n      (reset_n),
    .run          (run),
    .tck          (vji_tck),
    .period_start (period_start),
    .tck_rise     (tck_rise),
    .period_end   (period_end)
  );

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    data_d      = data_q;
    rsp_d       = rsp_q;
    bit_d       = bit_q;
    rsp_valid_d = rsp_valid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d = ST_UIR;
          ir_d    = cmd_ir;
          data_d  = cmd_data;
          bit_d   = '0;
        end
      end
      ST_UIR: if (period_end) state_d = ST_CDR;
      ST_CDR: if (period_end) state_d = ST_SDR;
      ST_SDR: begin
        // bit_q counts SDR periods already started; the last one ends at DR_WIDTH.
        if (period_start) bit_d = bit_q + 1'b1;
        if (tck_rise) rsp_d = {vji_tdo, rsp_q[DR_WIDTH-1:1]};
        if (period_end) begin
          data_d = data_q >> 1;
          if (bit_q == BITS_ALL) state_d = ST_UDR;
        end
      end
      ST_UDR: if (period_end) state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ir_q        <= '0;
      data_q      <= '0;
      rsp_q       <= '0;
      bit_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      data_q      <= data_d;
      rsp_q       <= rsp_d;
      bit_q       <= bit_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_q;
  assign vji_ir_in = ir_q;
  assign vji_uir   = (state_q == ST_UIR);
  assign vji_cdr   = (state_q == ST_CDR);
  assign vji_sdr   = (state_q == ST_SDR);
  assign vji_udr   = (state_q == ST_UDR);
  assign vji_rti   = (state_q == ST_IDLE) || (state_q == ST_RESP);
  assign vji_tdi   = (state_q == ST_SDR) && data_q[0];

endmodule

// File: tb/tb_project1_nios2_qsys_0_jtag_debug_host.sv
// Directed bench for the virtual-JTAG debug host (TCK_DIV=2 and TCK_DIV=1 instances).
module tb_project1_nios2_qsys_0_jtag_debug_host;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_valid1;
  logic        rsp_ready, rsp_ready1;
  logic [1:0]  cmd_ir;
  logic [37:0] cmd_data;
  logic        tdo_one;

  logic        cmd_ready, rsp_valid, vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, vji_tdo;
  logic [37:0] rsp_data;
  logic [1:0]  vji_ir_in;

  logic        cmd_ready1, rsp_valid1, tck1, tdi1, uir1, cdr1, sdr1, udr1, rti1;
  logic [37:0] rsp_data1;
  logic [1:0]  ir_in1;

  int passed = 0;
  int total  = 0;
  int n;
  int seen;

  assign vji_tdo = tdo_one ? 1'b1 : vji_tdi;

  always #5 clk = ~clk;

  project1_nios2_qsys_0_jtag_debug_host #(
    .TCK_DIV (2), .DR_WIDTH (38), .IR_WIDTH (2)
  ) dut (
    .clk (clk), .reset_n (reset_n),
    .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_ir (cmd_ir), .cmd_data (cmd_data),
    .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_data (rsp_data),
    .vji_tck (vji_tck), .vji_tdi (vji_tdi), .vji_uir (vji_uir), .vji_cdr (vji_cdr),
    .vji_sdr (vji_sdr), .vji_udr (vji_udr), .vji_rti (vji_rti),
    .vji_ir_in (vji_ir_in), .vji_tdo (vji_tdo)
  );

  project1_nios2_qsys_0_jtag_debug_host #(
    .TCK_DIV (1), .DR_WIDTH (38), .IR_WIDTH (2)
  ) dut1 (
    .clk (clk), .reset_n (reset_n),
    .cmd_valid (cmd_valid1), .cmd_ready (cmd_ready1), .cmd_ir (cmd_ir), .cmd_data (cmd_data),
    .rsp_valid (rsp_valid1), .rsp_ready (rsp_ready1), .rsp_data (rsp_data1),
    .vji_tck (tck1), .vji_tdi (tdi1), .vji_uir (uir1), .vji_cdr (cdr1),
    .vji_sdr (sdr1), .vji_udr (udr1), .vji_rti (rti1),
    .vji_ir_in (ir_in1), .vji_tdo (tdi1)
  );

  // Record vji_tdi at every SDR tck rise of the TCK_DIV=2 instance.
  logic [37:0] tdi_seq = '0;
  int          tdi_idx = 0;
  logic        tck_prev = 1'b0;
  always @(negedge clk) begin
    if (vji_uir) begin
      tdi_idx = 0;
      tdi_seq = '0;
    end else if (vji_sdr && vji_tck && !tck_prev) begin
      if (tdi_idx < 38) tdi_seq[tdi_idx] = vji_tdi;
      tdi_idx++;
    end
    tck_prev = vji_tck;
  end

  // Measure clk cycles between tck rises of the TCK_DIV=1 instance.
  int   cyc = 0;
  int   last_rise = -1;
  int   per_min = 1000;
  int   per_max = 0;
  int   rises1 = 0;
  logic tck1_prev = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (tck1 && !tck1_prev) begin
      if (last_rise >= 0) begin
        if (cyc - last_rise < per_min) per_min = cyc - last_rise;
        if (cyc - last_rise > per_max) per_max = cyc - last_rise;
      end
      last_rise = cyc;
      rises1++;
    end
    tck1_prev = tck1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_ir_in"}, vji_ir_in, 0);
    chk({tag, "_tck"}, vji_tck, 0);
    chk({tag, "_tdi"}, vji_tdi, 0);
    chk({tag, "_uir_cdr_sdr_udr"}, {vji_uir, vji_cdr, vji_sdr, vji_udr}, 0);
    chk({tag, "_rti"}, vji_rti, 1);
  endtask

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_valid1 = 1'b0;
    rsp_ready = 1'b0; rsp_ready1 = 1'b0; tdo_one = 1'b0;
    cmd_ir = '0; cmd_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Loopback transaction, default divider.
    cmd_ir = 2'b01; cmd_data = 38'h15_5555_5555; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("t1_uir", vji_uir, 1);
    chk("t1_cmd_ready", cmd_ready, 0);
    chk("t1_ir_in", vji_ir_in, 2'b01);
    chk("t1_rti", vji_rti, 0);
    for (n = 1; n <= 400; n++) begin
      @(posedge clk); #1;
      if (rsp_valid) break;
    end
    chk("t1_latency", n, 165);
    chk("t1_rsp_data", rsp_data, 38'h15_5555_5555);
    chk("t1_tdi_seq", tdi_seq, 38'h15_5555_5555);
    chk("t1_tdi_count", tdi_idx, 38);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("t1_done_cmd_ready", cmd_ready, 1);
    chk("t1_done_rsp_valid", rsp_valid, 0);

    // tdo tied high; rsp_ready held high throughout for zero-wait completion.
    tdo_one = 1'b1; rsp_ready = 1'b1;
    cmd_ir = 2'b10; cmd_data = 38'h2A_1234_5678; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (n = 1; n <= 400; n++) begin
      @(posedge clk); #1;
      if (rsp_valid) break;
    end
    chk("t2_latency", n, 165);
    chk("t2_rsp_data", rsp_data, 38'h3F_FFFF_FFFF);
    chk("t2_tdi_seq", tdi_seq, 38'h2A_1234_5678);
    chk("t2_ir_in", vji_ir_in, 2'b10);
    @(posedge clk); #1;
    rsp_ready = 1'b0; tdo_one = 1'b0;
    chk("t2_zero_wait_cmd_ready", cmd_ready, 1);
    chk("t2_zero_wait_rsp_valid", rsp_valid, 0);

    // New command offered mid-SDR must be ignored.
    cmd_ir = 2'b11; cmd_data = 38'h0F_0F0F_0F0F; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (n = 1; n <= 400; n++) begin
      @(posedge clk); #1;
      if (n >= 61 && n <= 63) begin
        chk("t3_busy_cmd_ready", cmd_ready, 0);
        chk("t3_busy_sdr", vji_sdr, 1);
      end
      if (n == 60) begin
        cmd_valid = 1'b1; cmd_ir = 2'b00; cmd_data = 38'h30_F0F0_F0F0;
      end
      if (n == 63) cmd_valid = 1'b0;
      if (rsp_valid) break;
    end
    chk("t3_latency", n, 165);
    chk("t3_rsp_data", rsp_data, 38'h0F_0F0F_0F0F);
    chk("t3_ir_in", vji_ir_in, 2'b11);

    // Back-pressure: response held stable while rsp_ready low.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("t4_hold_rsp_valid", rsp_valid, 1);
      chk("t4_hold_rsp_data", rsp_data, 38'h0F_0F0F_0F0F);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("t4_release_cmd_ready", cmd_ready, 1);

    // TCK_DIV=1 instance.
    cmd_ir = 2'b01; cmd_data = 38'h15_5555_5555; cmd_valid1 = 1'b1;
    @(posedge clk); #1;
    cmd_valid1 = 1'b0;
    for (n = 1; n <= 400; n++) begin
      @(posedge clk); #1;
      if (rsp_valid1) break;
    end
    chk("t5_latency", n, 83);
    chk("t5_rsp_data", rsp_data1, 38'h15_5555_5555);
    chk("t5_tck_period_min", per_min, 2);
    chk("t5_tck_period_max", per_max, 2);
    chk("t5_tck_rises", rises1, 41);
    rsp_ready1 = 1'b1;
    @(posedge clk); #1;
    rsp_ready1 = 1'b0;
    chk("t5_done_cmd_ready", cmd_ready1, 1);

    // Reset in the middle of SDR bit 20.
    cmd_ir = 2'b11; cmd_data = 38'h15_5555_5555; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (89) @(posedge clk);
    #1;
    chk("t6_in_sdr", vji_sdr, 1);
    chk("t6_rsp_partial", rsp_data[37:18], 20'h5_5555);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("t6_abort");
    @(posedge clk); #1;
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (rsp_valid || !cmd_ready) seen++;
    end
    chk("t6_no_rsp_after_abort", seen, 0);

    // Command accepted on the first edge after reset release.
    cmd_ir = 2'b10; cmd_data = 38'h00_0000_0001; cmd_valid = 1'b1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("t7_first_edge_uir", vji_uir, 1);
    chk("t7_first_edge_cmd_ready", cmd_ready, 0);
    for (n = 1; n <= 400; n++) begin
      @(posedge clk); #1;
      if (rsp_valid) break;
    end
    chk("t7_latency", n, 165);
    chk("t7_rsp_data", rsp_data, 38'h00_0000_0001);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
